// File: rtl/uc_seq.sv
// uc_seq: sequential control unit for the microc datapath.
//
// Decodes the 6-bit Opcode every cycle and drives the datapath control
// inputs. Skips are resolved one cycle after the compare against the
// registered zero/carry flags; a taken skip annuls the instruction
// presented in that cycle. A halt instruction parks the unit in HALT
// until reset.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-low reset
//   Opcode   current instruction opcode
//   zero     registered zero flag from the datapath
//   carry    registered carry flag from the datapath
//   s_skip   compare-instruction marker
//   s_inc    1 = PC+1, 0 = PC loads jump address
//   s_inm    1 = write-back source is the immediate
//   we       register-file write enable
//   ALUOp    ALU operation
//   halted   1 while in HALT
//   illegal  sticky undefined-opcode flag
//   retired  retired-instruction counter
//
// Optional feature: define UC_RETIRE_CNT_EN to build the retired-instruction
// counter; otherwise retired is tied to zero.

module uc_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             zero,
  input  logic             carry,
  output logic             s_skip,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic [2:0]       ALUOp,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    EVAL = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] cc;
  logic [1:0] cc_nx;
  logic       cond;
  logic       ill_set;
  logic       retire;

  always_comb begin
    s_skip   = 1'b0;
    s_inc    = 1'b1;
    s_inm    = 1'b0;
    we       = 1'b0;
    ALUOp    = 3'b000;
    state_nx = state;
    cc_nx    = cc;
    ill_set  = 1'b0;
    retire   = 1'b0;

    case (cc)
      2'b00:   cond = zero;
      2'b01:   cond = !zero;
      2'b10:   cond = carry;
      default: cond = !carry;
    endcase

    if (reset) begin
      case (state)
        BOOT: state_nx = RUN;
        HALT: s_inc = 1'b0;
        default: begin
          state_nx = RUN;
          // A true condition in EVAL annuls this instruction: outputs stay
          // quiet and none of its state effects are taken.
          if (!(state == EVAL && cond)) begin
            retire = 1'b1;
            if (Opcode[5]) begin
              ALUOp = Opcode[4:2];
              we    = 1'b1;
            end else begin
              case (Opcode[4:2])
                3'b001: begin
                  s_inm = 1'b1;
                  we    = 1'b1;
                end
                3'b010: begin
                  ALUOp    = 3'b011;
                  s_skip   = 1'b1;
                  state_nx = EVAL;
                  cc_nx    = Opcode[1:0];
                end
                3'b011: s_inc = 1'b0;
                3'b000: begin
                  if (Opcode[1:0] == 2'b01) state_nx = HALT;
                  else if (Opcode[1])       ill_set  = 1'b1;
                end
                default: ill_set = 1'b1;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign halted = reset && (state == HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= BOOT;
      cc      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      cc    <= cc_nx;
      if (ill_set) illegal <= 1'b1;
    end
  end

`ifdef UC_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)      cnt <= '0;
    else if (retire) cnt <= cnt + CNT_W'(1);
  end

  assign retired = cnt;
`else
  assign retired = '0;
`endif

endmodule

// File: doc/uc_seq.md
# uc_seq

Sequential control unit for the simple CPU: decodes the 6-bit `Opcode` from the `microc` datapath and drives its control inputs `s_skip`, `s_inc`, `s_inm`, `we`, `ALUOp` every cycle. Unlike a purely combinational decoder, it resolves skips one cycle after the compare using the datapath's registered `zero`/`carry` flags, annuls the following instruction when the skip is taken, and supports a halt state. It sits directly upstream of `microc`, and its outputs connect 1:1 to `microc`'s control inputs.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter (only used with `UC_RETIRE_CNT_EN`).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `Opcode`  in  6  current instruction opcode from `microc`.
- `zero`  in  1  registered zero flag from `microc`.
- `carry`  in  1  registered carry flag from `microc`.
- `s_skip`  out  1  compare-instruction marker to datapath.
- `s_inc`  out  1  1 = PC+1, 0 = PC loads jump address.
- `s_inm`  out  1  1 = write-back source is the immediate.
- `we`  out  1  register-file write enable.
- `ALUOp`  out  3  ALU operation.
- `halted`  out  1  1 while in HALT.
- `illegal`  out  1  sticky; set on an undefined opcode.
- `retired`  out  CNT_W  instructions retired (only with `UC_RETIRE_CNT_EN`).

## Operation
- **Decode** (`Opcode`; unannulled, RUN or EVAL):
  - `1aaaxx`: ALU op. `ALUOp=aaa`, `we=1`, `s_inc=1`.
  - `0001xx`: li. `s_inm=1`, `we=1`, `ALUOp=000`, `s_inc=1`.
  - `0010cc`: skip. `ALUOp=011`, `s_skip=1`, `we=0`, `s_inc=1`. Next state is EVAL with `cc` latched.
  - `0011xx`: jr. `s_inc=0`, `we=0`.
  - `000000`: nop.
  - `000001`: halt. Next state is HALT. The assembler encodes the halt instruction so that its jump field equals its own address.
  - All other codes: treated as nop, and `illegal` is set.
- **Quiet outputs:** `s_skip=0`, `s_inc=1`, `s_inm=0`, `we=0`, `ALUOp=000`.
- **States:** BOOT, RUN, EVAL, HALT.
  - BOOT: quiet outputs for one cycle, then RUN.
  - RUN: normal decode.
  - EVAL: evaluates `cc` against the current flags. `00` → `zero`, `01` → `!zero`, `10` → `carry`, `11` → `!carry`.
    - Condition true: the current instruction is annulled. Outputs are quiet, its side effects are dropped (no `illegal`, no HALT, no EVAL), and the next state is RUN.
    - Condition false: the current instruction is decoded normally, and the next state follows from that decode.
  - HALT: `we=0`, `s_inc=0`, other outputs 0, `halted=1`. Only reset exits HALT.
- **Boundary cases:**
  - A skip in EVAL that is not annulled re-enters EVAL with the new `cc`.
  - An annulled halt does not halt.
  - An annulled jr is not taken.
  - `illegal` is sticky until reset.

## Timing
- Control outputs are combinational from state, `Opcode`, and flags. The next state and all registers update on the rising `clk` edge.
- `reset=0` at an edge forces state BOOT and clears `illegal` and `retired`. This applies mid-operation in any state. While `reset=0`, outputs are quiet.
- Reset values: `s_inc=1`; all other outputs 0.
- Skip latency: the compare occurs in cycle N. The flags are valid in cycle N+1, when annulment is decided; the annulled instruction is the one presented in cycle N+1.
- HALT is entered at the edge that ends the halt instruction's cycle.

## Configuration
- `UC_RETIRE_CNT_EN` defined:
  - `retired` increments by 1 on each edge that ends a RUN/EVAL cycle whose instruction is not annulled.
  - It wraps from 2^CNT_W−1 to 0.
  - Halt counts once. BOOT and HALT cycles do not count.
- `UC_RETIRE_CNT_EN` undefined: no counter register, and `retired` is tied to 0.

## Test plan
- Reset and boot: hold `reset=0` for 2 cycles, then release. Expect quiet outputs for the reset cycles plus one BOOT cycle. With `Opcode=000100` in the next cycle, expect `s_inm=1`, `we=1`, `ALUOp=000`.
- Skip not taken: skipne (`001001`) → `s_skip=1`, `ALUOp=011`. Next cycle: `zero=1`, `Opcode=110000` (add) → `we=1`, `ALUOp=100`. With the counter enabled, `retired` advances by 2.
- Skip taken, annulling jr: skipeq (`001000`), then `zero=1` with `Opcode=001100` → `s_inc=1`, `we=0`. The cycle after that returns to normal decode. With the counter enabled, `retired` advances by 1.
- Back-to-back skips: skipc (`001010`); next cycle `carry=0`, `Opcode=001011` → re-enters EVAL. Following cycle: `carry=0` annuls the instruction.
- Halt and illegal: `Opcode=000010` sets `illegal=1`, which stays set. `Opcode=000001` → next cycle `halted=1`, `s_inc=0`, `we=0` for all opcodes. `reset=0` → `halted=0`, `illegal=0`.
- Counter wrap (`CNT_W=4`, `UC_RETIRE_CNT_EN`): 17 nops → `retired=1`.
